// File: rtl/nios_debug_pkg.sv
// Shared types and field positions for the Nios debug OCI memory controller.
// Imported by the arbiter and the controller top.
package nios_debug_pkg;

  localparam int AW_DEF       = 8;
  localparam int JDO_W        = 38;
  localparam int JDO_RD       = 35;
  localparam int JDO_LD       = 34;
  localparam int JDO_ADDR_LSB = 10;
  localparam int JDO_WD_MSB   = 34;
  localparam int JDO_WD_LSB   = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    REQ_JTAG = 1'b0,
    REQ_CPU  = 1'b1
  } req_id_t;

  function automatic logic multi_hot3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/nios_debug_rr_arb2.sv
// Two-way round-robin arbiter between the JTAG slot and the CPU port.
// The fairness pointer only moves when both sides ask in the same cycle.
module nios_debug_rr_arb2
  import nios_debug_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_req_jtag,
  input  logic i_req_cpu,
  output logic o_gnt_jtag,
  output logic o_gnt_cpu
);

  req_id_t r_last;
  logic    w_contest;

  assign w_contest = i_en & i_req_jtag & i_req_cpu;

  always_comb begin
    o_gnt_jtag = 1'b0;
    o_gnt_cpu  = 1'b0;
    if (w_contest) begin
      o_gnt_jtag = (r_last == REQ_CPU);
      o_gnt_cpu  = (r_last == REQ_JTAG);
    end else if (i_en) begin
      o_gnt_jtag = i_req_jtag;
      o_gnt_cpu  = i_req_cpu;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= REQ_CPU;
    end else if (w_contest) begin
      r_last <= (r_last == REQ_CPU) ? REQ_JTAG : REQ_CPU;
    end
  end

endmodule

// File: rtl/nios_debug_ocimem_ctrl.sv
// OCI RAM port shared between JTAG debug commands and the CPU slave port.
// Holds the JTAG address/data monitor registers and a one-deep JTAG slot.
module nios_debug_ocimem_ctrl
  import nios_debug_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [JDO_W-1:0]  jdo,
  input  logic [AW-1:0]     avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [AW-1:0]     ram_addr,
  output logic [31:0]       ram_wrdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rddata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t        r_state;
  state_t        w_state_nxt;
  req_id_t       r_rd_owner;

  logic          r_slot_vld;
  logic          r_slot_wr;
  logic [AW-1:0] r_slot_addr;
  logic [31:0]   r_slot_data;

  logic [AW-1:0] r_mon_a;
  logic [31:0]   r_mon_d;
  logic          r_ready;
  logic          r_error;

  logic          w_multi;
  logic          w_ld;
  logic          w_post_rd;
  logic          w_post_wr;
  logic          w_post;
  logic          w_slot_free;
  logic          w_accept;
  logic          w_drop;
  logic [AW-1:0] w_jaddr;
  logic [AW-1:0] w_cur_a;
  logic [31:0]   w_jwd;
  logic          w_cpu_req;
  logic          w_en;
  logic          w_gnt_jtag;
  logic          w_gnt_cpu;
  logic          w_jtag_done;
  logic          w_unused;

  assign w_unused = &{1'b0, jdo[JDO_W-1:JDO_RD+1], jdo[JDO_WD_LSB-1:0]};

  assign w_multi   = multi_hot3({take_action_ocimem_b,
                                 take_no_action_ocimem_a,
                                 take_action_ocimem_a});
  assign w_ld      = take_action_ocimem_a & jdo[JDO_LD] & ~w_multi;
  assign w_post_rd = ~w_multi
                   & ((take_action_ocimem_a & jdo[JDO_RD])
                      | take_no_action_ocimem_a);
  assign w_post_wr = ~w_multi & take_action_ocimem_b;
  assign w_post    = w_post_rd | w_post_wr;

  // A slot being granted this cycle can take the next command.
  assign w_slot_free = ~r_slot_vld | w_gnt_jtag;
  assign w_accept    = w_post & w_slot_free;
  assign w_drop      = w_post & ~w_slot_free;

  assign w_jaddr = jdo[JDO_ADDR_LSB +: AW];
  assign w_cur_a = w_ld ? w_jaddr : r_mon_a;
  assign w_jwd   = jdo[JDO_WD_MSB:JDO_WD_LSB];

  assign w_cpu_req = avs_read | avs_write;
  assign w_en      = (r_state == ST_IDLE) & ~reset;

  nios_debug_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_en),
    .i_req_jtag (r_slot_vld),
    .i_req_cpu  (w_cpu_req),
    .o_gnt_jtag (w_gnt_jtag),
    .o_gnt_cpu  (w_gnt_cpu)
  );

  assign w_jtag_done = (r_state == ST_RD_WAIT)
                     & (r_rd_owner == REQ_JTAG);

  always_comb begin
    w_state_nxt     = r_state;
    ram_addr        = '0;
    ram_wrdata      = '0;
    ram_be          = '0;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    avs_readdata    = '0;
    avs_waitrequest = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        unique case (1'b1)
          w_gnt_jtag: begin
            ram_addr = r_slot_addr;
            if (r_slot_wr) begin
              ram_we     = 1'b1;
              ram_wrdata = r_slot_data;
              ram_be     = 4'hF;
            end else begin
              ram_re      = 1'b1;
              w_state_nxt = ST_RD_WAIT;
            end
          end
          w_gnt_cpu: begin
            ram_addr = avs_address;
            if (avs_write) begin
              ram_we          = 1'b1;
              ram_wrdata      = avs_writedata;
              ram_be          = avs_byteenable;
              avs_waitrequest = 1'b0;
            end else begin
              ram_re      = 1'b1;
              w_state_nxt = ST_RD_WAIT;
            end
          end
          default: ;
        endcase
      end
      ST_RD_WAIT: begin
        w_state_nxt = ST_IDLE;
        // Reset in this cycle aborts the CPU completion.
        if (!reset && r_rd_owner == REQ_CPU) begin
          avs_waitrequest = 1'b0;
          avs_readdata    = ram_rddata;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rd_owner <= REQ_JTAG;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_jtag && !r_slot_wr) begin
        r_rd_owner <= REQ_JTAG;
      end else if (w_gnt_cpu && !avs_write) begin
        r_rd_owner <= REQ_CPU;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_vld  <= 1'b0;
      r_slot_wr   <= 1'b0;
      r_slot_addr <= '0;
      r_slot_data <= '0;
      r_mon_a     <= '0;
    end else begin
      if (w_accept) begin
        r_slot_vld  <= 1'b1;
        r_slot_wr   <= w_post_wr;
        r_slot_addr <= w_cur_a;
        r_slot_data <= w_jwd;
        r_mon_a     <= w_cur_a + 1'b1;
      end else begin
        if (w_gnt_jtag) r_slot_vld <= 1'b0;
        if (w_ld && !w_drop) r_mon_a <= w_jaddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mon_d <= '0;
      r_ready <= 1'b1;
      r_error <= 1'b0;
    end else begin
      if (w_jtag_done) begin
        r_mon_d <= ram_rddata;
        r_ready <= 1'b1;
      end
      // A fresh read posted while the old one lands keeps ready low.
      if (w_accept && w_post_rd) r_ready <= 1'b0;
      if (w_multi || w_drop) r_error <= 1'b1;
    end
  end

  assign MonDReg       = r_mon_d;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

endmodule

// File: tb/tb_nios_debug_ocimem_ctrl.sv
// Scoreboard bench for the OCI memory controller with a behavioural RAM.
// Expected RAM port operations and CPU read data are queued at stimulus time.
module tb_nios_debug_ocimem_ctrl;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ram_op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [37:0] jdo;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_be;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rddata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];
  ram_op_t     q_ram [$];
  logic [31:0] q_cpu [$];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  nios_debug_ocimem_ctrl #(.AW(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .jdo                     (jdo),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wrdata              (ram_wrdata),
    .ram_be                  (ram_be),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .ram_rddata              (ram_rddata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] = ram_wrdata[8*b +: 8];
    end
    if (ram_re) ram_rddata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we || ram_re) begin
        ram_op_t e;
        chk("ram_excl", 64'(ram_we & ram_re), 64'd0);
        chk("ram_op_expected", 64'(q_ram.size() != 0), 64'd1);
        if (q_ram.size() != 0) begin
          e = q_ram.pop_front();
          chk("ram_we", 64'(ram_we), 64'(e.we));
          chk("ram_addr", 64'(ram_addr), 64'(e.addr));
          if (e.we) begin
            chk("ram_wrdata", 64'(ram_wrdata), 64'(e.data));
            chk("ram_be", 64'(ram_be), 64'(e.be));
          end
        end
      end else begin
        chk("ram_idle", 64'({ram_addr, ram_wrdata, ram_be}), 64'd0);
      end
      if (avs_read && !avs_write && !avs_waitrequest) begin
        chk("cpu_rd_expected", 64'(q_cpu.size() != 0), 64'd1);
        if (q_cpu.size() != 0)
          chk("cpu_rddata", 64'(avs_readdata), 64'(q_cpu.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [37:0] mk_a(input logic rd, input logic ld,
                                       input logic [7:0] a);
    logic [37:0] v;
    v = '0;
    v[35] = rd;
    v[34] = ld;
    v[17:10] = a;
    return v;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic push_rd(input logic [7:0] a);
    ram_op_t e;
    e.we = 1'b0; e.addr = a; e.data = '0; e.be = '0;
    q_ram.push_back(e);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    ram_op_t e;
    e.we = 1'b1; e.addr = a; e.data = d; e.be = be;
    q_ram.push_back(e);
    for (int b = 0; b < 4; b++)
      if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    chk("rst_mond", 64'(MonDReg), 64'd0);
    chk("rst_ready", 64'(monitor_ready), 64'd1);
    chk("rst_error", 64'(monitor_error), 64'd0);
    chk("rst_wait", 64'(avs_waitrequest), 64'd1);
    chk("rst_ram_en", 64'({ram_we, ram_re}), 64'd0);
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
    end
    mem[8'h10] = 32'hDEAD_BEEF;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    ram_rddata = '0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0;
    take_action_ocimem_b = 0; jdo = '0;
    avs_address = '0; avs_read = 0; avs_write = 0;
    avs_writedata = '0; avs_byteenable = '0;
    do_reset();

    // JTAG load+read 0x10, then continue-read at 0x11
    take_action_ocimem_a = 1; jdo = mk_a(1, 1, 8'h10); push_rd(8'h10);
    cyc(); take_action_ocimem_a = 0; jdo = '0;
    chk("t1_rdy_lo", 64'(monitor_ready), 64'd0);
    cyc();
    chk("t1_rdy_wait", 64'(monitor_ready), 64'd0);
    cyc();
    chk("t1_mond", 64'(MonDReg), 64'hDEAD_BEEF);
    chk("t1_rdy_hi", 64'(monitor_ready), 64'd1);
    take_no_action_ocimem_a = 1; push_rd(8'h11);
    cyc(); take_no_action_ocimem_a = 0;
    cyc(2);
    chk("t1_mond_inc", 64'(MonDReg), 64'(exp_mem[8'h11]));

    // Address-only load 0xFF, write wraps address, read accepted in grant cycle
    take_action_ocimem_a = 1; jdo = mk_a(0, 1, 8'hFF);
    cyc(); take_action_ocimem_a = 0;
    take_action_ocimem_b = 1; jdo = mk_b(32'h1234_5678);
    push_wr(8'hFF, 32'h1234_5678, 4'hF);
    cyc(); take_action_ocimem_b = 0; jdo = '0;
    chk("t2_rdy_wr", 64'(monitor_ready), 64'd1);
    take_no_action_ocimem_a = 1; push_rd(8'h00);
    cyc(); take_no_action_ocimem_a = 0;
    cyc(2);
    chk("t2_mond_wrap", 64'(MonDReg), 64'(exp_mem[8'h00]));
    chk("t2_no_err", 64'(monitor_error), 64'd0);
    take_action_ocimem_a = 1; jdo = mk_a(1, 1, 8'hFF); push_rd(8'hFF);
    cyc(); take_action_ocimem_a = 0; jdo = '0;
    cyc(2);
    chk("t2_readback", 64'(MonDReg), 64'h1234_5678);

    // CPU read+write together acts as a byte-masked write
    avs_read = 1; avs_write = 1; avs_address = 8'h40;
    avs_writedata = 32'hCAFE_F00D; avs_byteenable = 4'b0101;
    push_wr(8'h40, 32'hCAFE_F00D, 4'b0101);
    #1;
    chk("t3_wr_done", 64'(avs_waitrequest), 64'd0);
    cyc(); avs_read = 0; avs_write = 0; #1;
    chk("t3_wait_hi", 64'(avs_waitrequest), 64'd1);
    take_action_ocimem_a = 1; jdo = mk_a(1, 1, 8'h40); push_rd(8'h40);
    cyc(); take_action_ocimem_a = 0; jdo = '0;
    cyc(2);
    chk("t3_merge", 64'(MonDReg), 64'(exp_mem[8'h40]));

    // Contest after reset: JTAG first, then CPU for one completion cycle
    do_reset();
    take_action_ocimem_a = 1; jdo = mk_a(1, 1, 8'h30); push_rd(8'h30);
    cyc(); take_action_ocimem_a = 0; jdo = '0;
    avs_read = 1; avs_address = 8'h20;
    push_rd(8'h20); q_cpu.push_back(exp_mem[8'h20]);
    #1;
    chk("t4_wait_c1", 64'(avs_waitrequest), 64'd1);
    cyc();
    chk("t4_wait_c2", 64'(avs_waitrequest), 64'd1);
    cyc();
    chk("t4_wait_c3", 64'(avs_waitrequest), 64'd1);
    chk("t4_mond", 64'(MonDReg), 64'(exp_mem[8'h30]));
    cyc();
    chk("t4_wait_lo", 64'(avs_waitrequest), 64'd0);
    chk("t4_rddata", 64'(avs_readdata), 64'(exp_mem[8'h20]));
    cyc(); avs_read = 0; #1;
    chk("t4_wait_after", 64'(avs_waitrequest), 64'd1);

    // Slot full behind a CPU read: second write dropped, error sticks
    avs_read = 1; avs_address = 8'h21;
    push_rd(8'h21); q_cpu.push_back(exp_mem[8'h21]);
    take_action_ocimem_b = 1; jdo = mk_b(32'h1111_2222);
    cyc();
    jdo = mk_b(32'h3333_4444);
    chk("t5_err_pre", 64'(monitor_error), 64'd0);
    cyc(); take_action_ocimem_b = 0; jdo = '0; avs_read = 0;
    chk("t5_err", 64'(monitor_error), 64'd1);
    push_wr(8'h31, 32'h1111_2222, 4'hF);
    take_no_action_ocimem_a = 1; push_rd(8'h32);
    cyc(); take_no_action_ocimem_a = 0;
    cyc(2);
    chk("t5_mond", 64'(MonDReg), 64'(exp_mem[8'h32]));
    cyc(5);
    chk("t5_err_sticky", 64'(monitor_error), 64'd1);

    // Simultaneous strobes: nothing accepted, address unchanged
    do_reset();
    take_action_ocimem_a = 1; take_action_ocimem_b = 1;
    jdo = mk_a(1, 1, 8'h55);
    cyc(); take_action_ocimem_a = 0; take_action_ocimem_b = 0; jdo = '0;
    chk("t6_err", 64'(monitor_error), 64'd1);
    take_no_action_ocimem_a = 1; push_rd(8'h00);
    cyc(); take_no_action_ocimem_a = 0;
    cyc(2);
    chk("t6_mond", 64'(MonDReg), 64'(exp_mem[8'h00]));

    // Reset landing in RD_WAIT aborts JTAG and CPU reads
    do_reset();
    take_action_ocimem_a = 1; jdo = mk_a(1, 1, 8'h10); push_rd(8'h10);
    cyc(); take_action_ocimem_a = 0; jdo = '0;
    cyc();
    reset = 1; #1;
    chk("t7_wait_rst", 64'(avs_waitrequest), 64'd1);
    cyc();
    chk("t7_mond", 64'(MonDReg), 64'd0);
    chk("t7_ready", 64'(monitor_ready), 64'd1);
    chk("t7_ram_en", 64'({ram_we, ram_re}), 64'd0);
    reset = 0;
    cyc();
    avs_read = 1; avs_address = 8'h22; push_rd(8'h22);
    cyc();
    reset = 1; #1;
    chk("t7_cpu_abort", 64'(avs_waitrequest), 64'd1);
    avs_read = 0;
    cyc(); reset = 0;
    cyc(2);
    chk("q_ram_empty", 64'(q_ram.size()), 64'd0);
    chk("q_cpu_empty", 64'(q_cpu.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
